// File: rtl/mem_fill_responder.sv
// Line fill/write responder with a fixed accept-to-response latency.
// Reads stream four word beats; writes and range errors answer with one beat.
module mem_fill_responder #(
  parameter int OFFSET_BITS    = 4,
  parameter int LINE_ADDR_BITS = 8,
  parameter int LATENCY        = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_we,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_data,
  output logic [1:0]   rsp_beat,
  output logic         rsp_last,
  output logic         rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int HI = OFFSET_BITS + LINE_ADDR_BITS;
  localparam int LINES = 1 << LINE_ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic         we_q, we_d;
  logic [127:0] wdata_q, wdata_d;
  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [31:0]  rsp_data_q, rsp_data_d;
  logic [1:0]   rsp_beat_q, rsp_beat_d;
  logic         rsp_last_q, rsp_last_d;
  logic         rsp_err_q, rsp_err_d;

  logic [127:0] mem_q [LINES];
  logic         mem_we;
  logic [LINE_ADDR_BITS-1:0] line_idx;
  logic [127:0] rd_line;
  logic         oor;
  logic         single;
  logic [1:0]   nxt_beat;

  assign line_idx = addr_q[OFFSET_BITS +: LINE_ADDR_BITS];
  assign rd_line  = mem_q[line_idx];
  assign oor      = |(addr_q >> HI);
  assign single   = oor || we_q;
  assign nxt_beat = rsp_beat_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_beat_d  = rsp_beat_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          we_d        = req_we;
          wdata_d     = req_wdata;
          cnt_d       = LAT_M1;
          state_d     = S_WAIT;
          req_ready_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_beat_d  = 2'd0;
          rsp_last_d  = single;
          rsp_err_d   = oor;
          rsp_data_d  = single ? 32'd0 : rd_line[31:0];
          mem_we      = !oor && we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          if (rsp_last_q) begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            rsp_data_d  = 32'd0;
            rsp_beat_d  = 2'd0;
            rsp_last_d  = 1'b0;
            rsp_err_d   = 1'b0;
          end else begin
            rsp_beat_d = nxt_beat;
            rsp_data_d = rd_line[{nxt_beat, 5'b0} +: 32];
            rsp_last_d = (nxt_beat == 2'd3);
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      wdata_q     <= 128'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_beat_q  <= 2'd0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_beat_q  <= rsp_beat_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage survives reset; it only changes on a committed write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[line_idx] <= wdata_q;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_beat  = rsp_beat_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

endmodule
